// File: rtl/semaforo_pkg.sv
// Shared types, lamp codes and default phase durations for the traffic light.
// SEMAFORO_PEATON_EN adds the PEATON state to the state encoding.
package semaforo_pkg;

  localparam int W_DEF = 4;
  localparam int T_VERDE_DEF = 4;
  localparam int T_AMARILLO_DEF = 2;
  localparam int T_TODO_ROJO_DEF = 1;
  localparam int T_PEATON_DEF = 3;

  localparam logic [2:0] VERDE = 3'b001;
  localparam logic [2:0] AMARILLO = 3'b010;
  localparam logic [2:0] ROJO = 3'b100;

  typedef enum logic [2:0] {
    VERDE_A    = 3'd0,
    AMARILLO_A = 3'd1,
    ROJO_1     = 3'd2,
    VERDE_B    = 3'd3,
    AMARILLO_B = 3'd4,
    ROJO_2     = 3'd5
`ifdef SEMAFORO_PEATON_EN
    ,
    PEATON     = 3'd6
`endif
  } estado_t;

  function automatic logic [2:0] lamp_a(estado_t s);
    logic [2:0] l;
    l = ROJO;
    unique case (s)
      VERDE_A:    l = VERDE;
      AMARILLO_A: l = AMARILLO;
      default:    l = ROJO;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] lamp_b(estado_t s);
    logic [2:0] l;
    l = ROJO;
    unique case (s)
      VERDE_B:    l = VERDE;
      AMARILLO_B: l = AMARILLO;
      default:    l = ROJO;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Phase tick counter with terminal-count compare.
// DONE is high on the TICK that ends a phase of DUR ticks.
module temporizador_fase #(
  parameter int W = 4
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         TICK,
  input  logic [W-1:0] DUR,
  input  logic         CLR,
  output logic [W-1:0] CNT,
  output logic         DONE
);

  assign DONE = TICK && (CNT == DUR - W'(1));

  // count ticks; cleared on reset or when the phase ends
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      CNT <= '0;
    end else if (CLR) begin
      CNT <= '0;
    end else if (TICK) begin
      CNT <= CNT + W'(1);
    end
  end

endmodule

// File: rtl/control_semaforo.sv
// Two-road traffic light controller with optional pedestrian phase.
// Define SEMAFORO_PEATON_EN to build the pedestrian request/walk function.
module control_semaforo
  import semaforo_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int T_VERDE = T_VERDE_DEF,
  parameter int T_AMARILLO = T_AMARILLO_DEF,
  parameter int T_TODO_ROJO = T_TODO_ROJO_DEF,
  parameter int T_PEATON = T_PEATON_DEF
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         TICK,
  input  logic         PED_REQ,
  output logic [2:0]   LIGHT_A,
  output logic [2:0]   LIGHT_B,
  output logic         PED_WALK,
  output logic         PED_ACK,
  output logic [W-1:0] PHASE_CNT
);

  estado_t state;
  estado_t state_next;
  logic [W-1:0] dur;
  logic done;

  temporizador_fase #(.W(W)) u_tmr (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .TICK (TICK),
    .DUR  (dur),
    .CLR  (done),
    .CNT  (PHASE_CNT),
    .DONE (done)
  );

  // duration of the current phase
  always_comb begin
    dur = W'(T_PEATON);
    unique case (state)
      VERDE_A:    dur = W'(T_VERDE);
      AMARILLO_A: dur = W'(T_AMARILLO);
      ROJO_1:     dur = W'(T_TODO_ROJO);
      VERDE_B:    dur = W'(T_VERDE);
      AMARILLO_B: dur = W'(T_AMARILLO);
      ROJO_2:     dur = W'(T_TODO_ROJO);
      default:    dur = W'(T_PEATON);
    endcase
  end

`ifdef SEMAFORO_PEATON_EN
  logic pending;
  logic pending_next;
  logic req_take;

  // latch a new request; ROJO_2 exit consumes it
  always_comb begin
    req_take = PED_REQ && !pending && (state != PEATON);
    pending_next = pending;
    if (req_take) pending_next = 1'b1;
    if (done && state == ROJO_2 && pending)
      pending_next = 1'b0;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = PED_REQ;
`endif

  // next phase at the end of the current one
  always_comb begin
    state_next = state;
    if (done) begin
      unique case (state)
        VERDE_A:    state_next = AMARILLO_A;
        AMARILLO_A: state_next = ROJO_1;
        ROJO_1:     state_next = VERDE_B;
        VERDE_B:    state_next = AMARILLO_B;
        AMARILLO_B: state_next = ROJO_2;
`ifdef SEMAFORO_PEATON_EN
        ROJO_2:
          state_next = pending ? PEATON : VERDE_A;
        PEATON:     state_next = VERDE_A;
`else
        ROJO_2:     state_next = VERDE_A;
`endif
        default:    state_next = VERDE_A;
      endcase
    end
  end

  // state and lamp registers, lamps follow next state
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= VERDE_A;
      LIGHT_A <= VERDE;
      LIGHT_B <= ROJO;
`ifdef SEMAFORO_PEATON_EN
      pending  <= 1'b0;
      PED_ACK  <= 1'b0;
      PED_WALK <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      LIGHT_A <= lamp_a(state_next);
      LIGHT_B <= lamp_b(state_next);
`ifdef SEMAFORO_PEATON_EN
      pending  <= pending_next;
      PED_ACK  <= req_take;
      PED_WALK <= (state_next == PEATON);
`endif
    end
  end

`ifndef SEMAFORO_PEATON_EN
  assign PED_ACK = 1'b0;
  assign PED_WALK = 1'b0;
`endif

endmodule

// File: tb/tb_control_semaforo.sv
// Self-checking bench for control_semaforo against a phase-table model.
// Pedestrian checks follow SEMAFORO_PEATON_EN when it is defined.
module tb_control_semaforo;

`ifdef SEMAFORO_PEATON_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       TICK;
  logic       PED_REQ;
  logic [2:0] LIGHT_A;
  logic [2:0] LIGHT_B;
  logic       PED_WALK;
  logic       PED_ACK;
  logic [3:0] PHASE_CNT;

  control_semaforo dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .TICK     (TICK),
    .PED_REQ  (PED_REQ),
    .LIGHT_A  (LIGHT_A),
    .LIGHT_B  (LIGHT_B),
    .PED_WALK (PED_WALK),
    .PED_ACK  (PED_ACK),
    .PHASE_CNT(PHASE_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  // phases 0..5 are the base cycle, 6 is the pedestrian phase
  int dur[7]    = '{4, 2, 1, 4, 2, 1, 3};
  int la_tab[7] = '{1, 2, 4, 4, 4, 4, 4};
  int lb_tab[7] = '{4, 4, 4, 1, 2, 4, 4};

  int m_ph;
  int m_cnt;
  bit m_pend;
  bit m_ack;

  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(bit r, bit t, bit q);
    bit op;
    int oph;
    op = m_pend;
    oph = m_ph;
    if (r) begin
      m_ph = 0;
      m_cnt = 0;
      m_pend = 0;
      m_ack = 0;
      return;
    end
    m_ack = 0;
    if (PEN && q && !op && oph != 6) begin
      m_pend = 1;
      m_ack = 1;
    end
    if (t) begin
      if (m_cnt == dur[oph] - 1) begin
        m_cnt = 0;
        if (oph == 5) begin
          if (PEN && op) begin
            m_ph = 6;
            m_pend = 0;
          end else begin
            m_ph = 0;
          end
        end else if (oph == 6) begin
          m_ph = 0;
        end else begin
          m_ph = oph + 1;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(bit r, bit t, bit q);
    RESET = r;
    TICK = t;
    PED_REQ = q;
    @(posedge CLOCK);
    model(r, t, q);
    #1;
    chk("light_a", LIGHT_A, la_tab[m_ph]);
    chk("light_b", LIGHT_B, lb_tab[m_ph]);
    chk("ped_walk", PED_WALK, (m_ph == 6));
    chk("ped_ack", PED_ACK, m_ack);
    chk("phase_cnt", PHASE_CNT, m_cnt);
  endtask

  initial begin
    RESET = 1'b1;
    TICK = 1'b0;
    PED_REQ = 1'b0;
    m_ph = 0;
    m_cnt = 0;
    m_pend = 0;
    m_ack = 0;

    step(1, 1, 1);
    chk("rst_a", LIGHT_A, 3'b001);
    chk("rst_b", LIGHT_B, 3'b100);
    chk("rst_cnt", PHASE_CNT, 0);

    // base sequence with TICK every cycle
    for (int i = 1; i <= 14; i++) begin
      step(0, 1, 0);
      if (i == 7) chk("seq7_b", LIGHT_B, 3'b001);
      if (i == 13) chk("seq13_a", LIGHT_A, 3'b100);
    end
    chk("seq14_a", LIGHT_A, 3'b001);
    chk("seq14_cnt", PHASE_CNT, 0);

    // TICK every third cycle stretches VERDE_A to 12
    step(1, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, (k % 3) == 0, 0);
      if (k == 11) begin
        chk("slow11_a", LIGHT_A, 3'b001);
        chk("slow11_cnt", PHASE_CNT, 3);
      end
    end
    chk("slow12_a", LIGHT_A, 3'b010);
    chk("slow12_cnt", PHASE_CNT, 0);

`ifdef SEMAFORO_PEATON_EN
    // request during VERDE_B, served after ROJO_2
    step(1, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    step(0, 1, 1);
    chk("ack_pulse", PED_ACK, 1);
    step(0, 1, 0);
    chk("ack_once", PED_ACK, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    chk("peaton_walk", PED_WALK, 1);
    chk("peaton_a", LIGHT_A, 3'b100);
    chk("peaton_b", LIGHT_B, 3'b100);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("after_ped_a", LIGHT_A, 3'b001);
    chk("after_ped_walk", PED_WALK, 0);

    // request first seen on the ROJO_2 exit edge
    step(1, 1, 0);
    for (int i = 0; i < 13; i++) step(0, 1, 0);
    step(0, 1, 1);
    chk("late_a", LIGHT_A, 3'b001);
    chk("late_ack", PED_ACK, 1);
    for (int j = 1; j <= 17; j++) begin
      step(0, 1, 1);
      if (j == 14) chk("late_walk", PED_WALK, 1);
    end
    step(0, 1, 0);
`else
    // pedestrian input has no effect in this build
    step(1, 1, 0);
    for (int i = 1; i <= 14; i++) begin
      step(0, 1, i[0]);
      chk("noped_ack", PED_ACK, 0);
    end
    chk("noped_a", LIGHT_A, 3'b001);
`endif

    // reset in the middle of VERDE_B
    step(1, 1, 0);
    for (int i = 0; i < 9; i++) step(0, 1, i == 8);
    chk("mid_cnt", PHASE_CNT, 2);
    step(1, 1, 1);
    chk("mid_a", LIGHT_A, 3'b001);
    chk("mid_cnt0", PHASE_CNT, 0);
    chk("mid_ack", PED_ACK, 0);
    for (int i = 0; i < 14; i++) step(0, 1, 0);
    chk("mid_nowalk", PED_WALK, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 50) == 0,
           ($urandom % 3) != 0,
           ($urandom % 8) == 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/control_semaforo.md
CONTROL_SEMAFORO -- requirements
Module: control_semaforo

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning phase-counter width in bits.
REQ-002 The block SHALL have parameters T_VERDE=4, T_AMARILLO=2, T_TODO_ROJO=1 and T_PEATON=3, each giving a phase duration in TICK pulses, each legal range 1..2^W-1.
REQ-003 The block SHALL have port CLOCK, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port RESET, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port TICK, input, 1, a one-cycle timebase pulse fed by the upstream counter's END_CNT output.
REQ-006 The block SHALL have port PED_REQ, input, 1, the pedestrian request as a level.
REQ-007 The block SHALL have port LIGHT_A, output, 3, the road A lamp: 3'b001 green, 3'b010 yellow, 3'b100 red.
REQ-008 The block SHALL have port LIGHT_B, output, 3, the road B lamp, with the same encoding as LIGHT_A.
REQ-009 The block SHALL have port PED_WALK, output, 1, the pedestrian walk lamp.
REQ-010 The block SHALL have port PED_ACK, output, 1, a one-cycle acknowledge pulse for a pedestrian request.
REQ-011 The block SHALL have port PHASE_CNT, output, W, the TICKs elapsed in the current phase.

Function
REQ-012 The FSM SHALL have states VERDE_A, AMARILLO_A, ROJO_1, VERDE_B, AMARILLO_B, ROJO_2 and PEATON.
REQ-013 Outputs per state SHALL be Moore, registered with the state:
- VERDE_A: A green, B red.
- AMARILLO_A: A yellow, B red.
- VERDE_B: A red, B green.
- AMARILLO_B: A red, B yellow.
- ROJO_1, ROJO_2 and PEATON: both red.
REQ-014 PHASE_CNT SHALL increment by 1 on each cycle with TICK=1, and hold on each cycle with TICK=0.
REQ-015 When TICK=1 and PHASE_CNT equals the current phase duration minus 1, the state SHALL advance on that edge and PHASE_CNT SHALL return to 0.
REQ-016 The base sequence SHALL be VERDE_A -> AMARILLO_A -> ROJO_1 -> VERDE_B -> AMARILLO_B -> ROJO_2 -> VERDE_A.
REQ-017 A pending flag SHALL set on the first cycle PED_REQ=1 while the flag is clear and the state is not PEATON.
REQ-018 PED_ACK SHALL pulse exactly once, for the single cycle after the pending flag sets.
REQ-019 PED_REQ SHALL be ignored while in PEATON, and further requests while the flag is set SHALL give no extra ACK.
REQ-020 On ROJO_2 exit, if pending is set, the FSM SHALL go to PEATON rather than VERDE_A and clear pending.
REQ-021 PEATON SHALL assert PED_WALK=1 for T_PEATON TICKs, then the FSM SHALL go to VERDE_A.
REQ-022 A request first sampled on the same edge as ROJO_2 exit SHALL NOT divert that exit; it SHALL be served at the next ROJO_2 exit.
REQ-023 PHASE_CNT SHALL never exceed the duration minus 1, and SHALL never wrap.

Reset
REQ-024 On RESET=1 at a clock edge, the block SHALL set state VERDE_A, PHASE_CNT 0, pending 0, PED_ACK 0 and PED_WALK 0, overriding TICK and PED_REQ.
REQ-025 RESET asserted mid-phase, including in PEATON, SHALL abort the phase with no lamp glitch beyond the reset state.

Configuration
REQ-026 Macro SEMAFORO_PEATON_EN defined SHALL compile in the pedestrian function: the pending flag, PEATON, PED_WALK and PED_ACK behaviour.
REQ-027 With SEMAFORO_PEATON_EN undefined:
- PED_REQ is unused.
- PED_WALK and PED_ACK are constant 0.
- PEATON is absent.
- ROJO_2 always exits to VERDE_A.
- All ports are still present.

Structure
REQ-028 The state encodings, the lamp codes (VERDE, AMARILLO, ROJO) and the default durations SHALL live in shared package semaforo_pkg.
REQ-029 The phase counter with its terminal-count compare SHALL be sub-module temporizador_fase (inputs CLOCK, RESET, TICK, DUR, CLR; outputs CNT, DONE).
REQ-030 The FSM SHALL remain in control_semaforo.

Verification (defaults, TICK=1 every cycle)
REQ-031 Release reset with no request -> VERDE_A for 4 cycles, AMARILLO_A 2, ROJO_1 1, VERDE_B 4, AMARILLO_B 2, ROJO_2 1, then VERDE_A again at cycle 14.
REQ-032 TICK only every 3rd cycle -> VERDE_A lasts exactly 12 cycles, with PHASE_CNT stepping 0,1,2,3.
REQ-033 PED_REQ high 1 cycle during VERDE_B -> PED_ACK one pulse the next cycle; after ROJO_2 comes PEATON for 3 cycles with PED_WALK=1 and LIGHT_A=LIGHT_B=3'b100; then VERDE_A.
REQ-034 PED_REQ first high on the ROJO_2 exit edge -> VERDE_A follows and PEATON occurs after the next ROJO_2; PED_REQ held high through PEATON -> no second ACK.
REQ-035 RESET pulsed at PHASE_CNT=2 of VERDE_B -> next cycle state VERDE_A, PHASE_CNT 0, pending 0.
REQ-036 Build without SEMAFORO_PEATON_EN and toggle PED_REQ -> PED_ACK and PED_WALK stay 0 and the 14-cycle sequence is unchanged.
